// File: rtl/button_debounce.sv
// button_debounce: debounces one raw push-button on a free-running tick.
// It produces a clean level, single-cycle press, release and long-press
// strobes, and a long-held flag.
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous button pin
//   btn_level     debounced state, 1 = pressed
//   press_pulse   1-cycle strobe on a debounced press
//   release_pulse 1-cycle strobe on a debounced release
//   long_pulse    1-cycle strobe when a press has been held LONG_MS ticks
//   long_held     1 from long_pulse until the debounced release
module button_debounce #(
  parameter int unsigned TICK_DIV    = 24000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);

  // Each counter is sized to hold its own maximum value, minimum 1 bit.
  localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_MS > 2) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int unsigned HOLD_W = (LONG_MS > 2) ? $clog2(LONG_MS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

  // Pin level that means "not pressed".
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEB_P   = 3'd1,
    PRESSED = 3'd2,
    LONG    = 3'd3,
    DEB_R   = 3'd4
  } state_t;

  logic              sync1, sync2;
  logic              p_c;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;

  state_t            state, state_n;
  logic [DB_W-1:0]   db_cnt, db_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              level_n, press_n, release_n, long_pulse_n, long_held_n;

  // Two-flop synchroniser, preloaded with the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Normalised input: 1 means pressed regardless of pin polarity.
  assign p_c = sync2 ^ REL_LVL;

  // Free-running debounce tick; never restarted by button activity.
  assign tick_c = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Next-state and next-output logic; an input change takes priority over a tick.
  always_comb begin
    state_n      = state;
    db_cnt_n     = db_cnt;
    hold_cnt_n   = hold_cnt;
    level_n      = btn_level;
    long_held_n  = long_held;
    press_n      = 1'b0;
    release_n    = 1'b0;
    long_pulse_n = 1'b0;

    case (state)
      IDLE: begin
        if (p_c) begin
          state_n  = DEB_P;
          db_cnt_n = '0;
        end
      end

      DEB_P: begin
        if (!p_c) begin
          state_n = IDLE;
        end else if (tick_c) begin
          if (db_cnt == DB_LAST) begin
            state_n    = PRESSED;
            press_n    = 1'b1;
            level_n    = 1'b1;
            hold_cnt_n = '0;
          end else begin
            db_cnt_n = db_cnt + DB_W'(1);
          end
        end
      end

      PRESSED: begin
        if (!p_c) begin
          state_n  = DEB_R;
          db_cnt_n = '0;
        end else if (tick_c) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n      = LONG;
            long_pulse_n = 1'b1;
            long_held_n  = 1'b1;
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
      end

      LONG: begin
        if (!p_c) begin
          state_n  = DEB_R;
          db_cnt_n = '0;
        end
      end

      DEB_R: begin
        // A bounce back to pressed resumes where it left off; hold_cnt is kept.
        if (p_c) begin
          state_n = long_held ? LONG : PRESSED;
        end else if (tick_c) begin
          if (db_cnt == DB_LAST) begin
            state_n     = IDLE;
            release_n   = 1'b1;
            level_n     = 1'b0;
            long_held_n = 1'b0;
          end else begin
            db_cnt_n = db_cnt + DB_W'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      state         <= state_n;
      db_cnt        <= db_cnt_n;
      hold_cnt      <= hold_cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_pulse_n;
      long_held     <= long_held_n;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed and random stimulus for button_debounce,
// checked every cycle against a behavioural model.
module tb_button_debounce;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DEBOUNCE_MS = 3;
  localparam int unsigned LONG_MS     = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, press_pulse, release_pulse, long_pulse, long_held;

  int tests = 0;
  int fails = 0;

  // Pulses observed on the DUT, used for the event-count checks.
  int seen_press = 0;
  int seen_rel   = 0;
  int seen_long  = 0;

  // Behavioural model state.
  int   cyc;        // edges since reset released
  logic m_s1, m_s2; // raw pin samples still in flight through the synchroniser
  logic m_level;    // debounced level
  logic m_pending;  // synced input disagrees with the debounced level
  int   m_ticks;    // ticks counted while disagreeing
  int   m_hold;     // ticks counted while held pressed
  logic m_long;
  logic e_press, e_rel, e_long;

  button_debounce #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .LONG_MS     (LONG_MS),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .long_held     (long_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: the input must disagree with the debounced level
  // for DEBOUNCE_MS whole ticks; a tick coinciding with an input change is lost.
  task automatic model_edge(input logic r, input logic b);
    logic p, tk, was_pending;
    e_press = 1'b0;
    e_rel   = 1'b0;
    e_long  = 1'b0;
    if (r) begin
      cyc       = 0;
      m_s1      = 1'b1;
      m_s2      = 1'b1;
      m_level   = 1'b0;
      m_pending = 1'b0;
      m_ticks   = 0;
      m_hold    = 0;
      m_long    = 1'b0;
    end else begin
      cyc++;
      tk   = ((cyc % TICK_DIV) == 0);
      p    = (m_s2 == 1'b0);
      m_s2 = m_s1;
      m_s1 = b;
      if (p != m_level) begin
        if (!m_pending) begin
          m_pending = 1'b1;
          m_ticks   = 0;
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == DEBOUNCE_MS) begin
            m_level   = p;
            m_pending = 1'b0;
            if (p) begin
              e_press = 1'b1;
              m_hold  = 0;
            end else begin
              e_rel  = 1'b1;
              m_long = 1'b0;
            end
          end
        end
      end else begin
        was_pending = m_pending;
        m_pending   = 1'b0;
        if (m_level && !was_pending && !m_long && tk) begin
          m_hold++;
          if (m_hold == LONG_MS) begin
            e_long = 1'b1;
            m_long = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then check outputs after the edge.
  task automatic step(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    model_edge(r, b);
    #1;
    chk("btn_level", btn_level, m_level);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("long_pulse", long_pulse, e_long);
    chk("long_held", long_held, m_long);
    if (press_pulse === 1'b1) seen_press++;
    if (release_pulse === 1'b1) seen_rel++;
    if (long_pulse === 1'b1) seen_long++;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int lat, bp, br, bl;
    logic found;
    logic lvl;
    int len;

    // Reset with the button already pressed; press still needs full debounce.
    btn_in = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      if (!found && press_pulse === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end
    end
    chk("post_reset_press_seen", found, 1'b1);
    chk("post_reset_press_window", (lat >= 12 && lat <= 16), 1'b1);
    hold(1'b1, 30);

    // Clean press held long enough for a long press, then released.
    bp = seen_press; br = seen_rel; bl = seen_long;
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 45; i++) begin
      step(1'b0, 1'b0);
      if (!found && press_pulse === 1'b1) begin
        found = 1'b1;
        lat   = i;
      end
    end
    chk("press_seen", found, 1'b1);
    chk("press_window", (lat >= 12 && lat <= 16), 1'b1);
    chk_int("long_count", seen_long - bl, 1);
    chk("long_held_while_pressed", long_held, 1'b1);
    hold(1'b1, 30);
    chk_int("press_count", seen_press - bp, 1);
    chk_int("release_count", seen_rel - br, 1);
    chk("level_after_release", btn_level, 1'b0);

    // Short glitch is rejected.
    bp = seen_press;
    hold(1'b0, 6);
    hold(1'b1, 20);
    chk_int("glitch_no_press", seen_press - bp, 0);

    // Bounce while pressed: no release, no second press, long still fires.
    bp = seen_press; br = seen_rel; bl = seen_long;
    hold(1'b0, 20);
    hold(1'b1, 5);
    hold(1'b0, 40);
    chk_int("bounce_press_count", seen_press - bp, 1);
    chk_int("bounce_no_release", seen_rel - br, 0);
    chk_int("bounce_long_count", seen_long - bl, 1);
    hold(1'b1, 30);

    // Reset in mid-press: silent clear, then a fresh press.
    bp = seen_press; br = seen_rel;
    hold(1'b0, 20);
    step(1'b0, 1'b1);
    chk("reset_clears_level", btn_level, 1'b0);
    hold(1'b0, 20);
    chk_int("reset_press_count", seen_press - bp, 2);
    chk_int("reset_no_release", seen_rel - br, 0);
    hold(1'b1, 30);

    // Random bouncing runs with occasional resets.
    for (int k = 0; k < 150; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      if ($urandom_range(0, 39) == 0) step(lvl, 1'b1);
      hold(lvl, len);
    end
    hold(1'b1, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
